// File: rtl/sweep_acq_controller.sv
// Sweep-acquisition engine: steps a 10-bit DAC, reloads slow control, runs one acquisition per code
// and writes a header/trailer record pair per step. Optional macro SWEEP_ACQ_TIMEOUT_EN adds an ACQ timeout.
`timescale 1ns/1ps
module sweep_acq_controller #(
  parameter logic [15:0] TAIL_WORD      = 16'hFFFF,
  parameter logic [15:0] SETTLE_CYCLES  = 16'd1000
`ifdef SWEEP_ACQ_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd40000000
`endif
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        SweepStartStop,
  input  logic [9:0]  StartDac,
  input  logic [9:0]  EndDac,
  input  logic [15:0] MaxPackageNumber,
  input  logic        SCLoadDone,
  input  logic [15:0] ParallelData,
  input  logic        ParallelData_en,
  output logic [9:0]  SweepAcq10BitDac,
  output logic        SweepAcqMicrorocSCParameterLoad,
  output logic        SweepAcqMicrorocAcqStartStop,
  output logic        SweepAcqForceMicrorocAcqReset,
  output logic [15:0] SweepAcqData,
  output logic        SweepAcqData_en,
  output logic        SweepAcqDone
);

  typedef enum logic [3:0] {
    IDLE, LOAD, WAIT_LOAD, SETTLE, HEADER, ACQ, STOP, TRAILER, NEXT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  dac_q, dac_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] pkg_q, pkg_d;
  logic [15:0] data_q, data_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        abort_q, abort_d;
  logic        load_q, load_d;
  logic        acq_q, acq_d;
  logic        force_q, force_d;
  logic        data_en_q, data_en_d;
  logic        done_q, done_d;
`ifdef SWEEP_ACQ_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic [32:0] timer_inc;
`endif

  logic        tail_hit;
  logic        abort_req;
  logic        settle_last;
  logic [15:0] pkg_inc;
  logic [16:0] settle_inc;

  function automatic logic [15:0] trailer_word(input logic [15:0] cnt);
`ifdef SWEEP_ACQ_TIMEOUT_EN
    return {1'b1, cnt[14:0]};
`else
    return cnt;
`endif
  endfunction

  assign tail_hit    = ParallelData_en && (ParallelData == TAIL_WORD);
  assign pkg_inc     = pkg_q + 16'd1;
  assign settle_inc  = {1'b0, settle_q} + 17'd1;
  assign settle_last = settle_inc >= {1'b0, SETTLE_CYCLES};
  assign abort_req   = !SweepStartStop && (state_q != IDLE) && (state_q != DONE);
`ifdef SWEEP_ACQ_TIMEOUT_EN
  assign timer_inc   = {1'b0, timer_q} + 33'd1;
`endif

  always_comb begin
    state_d    = state_q;
    dac_d      = dac_q;
    settle_d   = settle_q;
    pkg_d      = pkg_q;
    data_d     = data_q;
    stop_cnt_d = 1'b0;
    abort_d    = abort_q;
    load_d     = 1'b0;
    data_en_d  = 1'b0;
    done_d     = 1'b0;
`ifdef SWEEP_ACQ_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (SweepStartStop) begin
          if (StartDac > EndDac) begin
            state_d = DONE;
          end else begin
            dac_d   = StartDac;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        load_d  = 1'b1;
        state_d = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (SCLoadDone) begin
          settle_d = 16'd0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_last) state_d = HEADER;
        else             settle_d = settle_inc[15:0];
      end
      HEADER: begin
        data_d    = {6'b110000, dac_q};
        data_en_d = 1'b1;
        pkg_d     = 16'd0;
`ifdef SWEEP_ACQ_TIMEOUT_EN
        timer_d   = 32'd0;
`endif
        state_d   = (MaxPackageNumber == 16'd0) ? TRAILER : ACQ;
      end
      ACQ: begin
        if (tail_hit) begin
          pkg_d = pkg_inc;
          if (pkg_inc == MaxPackageNumber) state_d = STOP;
        end
`ifdef SWEEP_ACQ_TIMEOUT_EN
        timer_d = timer_inc[31:0];
        if (timer_inc >= {1'b0, TIMEOUT_CYCLES}) state_d = STOP;
`endif
      end
      STOP: begin
        if (stop_cnt_q) state_d = abort_q ? IDLE : TRAILER;
        else            stop_cnt_d = 1'b1;
      end
      TRAILER: begin
        data_d    = trailer_word(pkg_q);
        data_en_d = 1'b1;
        state_d   = NEXT;
      end
      NEXT: begin
        if (dac_q == EndDac) begin
          state_d = DONE;
        end else begin
          dac_d   = dac_q + 10'd1;
          state_d = LOAD;
        end
      end
      DONE: begin
        done_d = SweepStartStop;
        if (!SweepStartStop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort funnels every active state through the 2-cycle reset pulse and drops pending records.
    if (abort_req) begin
      abort_d   = 1'b1;
      load_d    = 1'b0;
      data_en_d = 1'b0;
      if (state_q == STOP) state_d = stop_cnt_q ? IDLE : STOP;
      else                 state_d = STOP;
    end

    acq_d   = (state_d == ACQ);
    force_d = (state_d == STOP);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dac_q      <= 10'd0;
      settle_q   <= 16'd0;
      pkg_q      <= 16'd0;
      data_q     <= 16'd0;
      stop_cnt_q <= 1'b0;
      abort_q    <= 1'b0;
      load_q     <= 1'b0;
      acq_q      <= 1'b0;
      force_q    <= 1'b0;
      data_en_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef SWEEP_ACQ_TIMEOUT_EN
      timer_q    <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      dac_q      <= dac_d;
      settle_q   <= settle_d;
      pkg_q      <= pkg_d;
      data_q     <= data_d;
      stop_cnt_q <= stop_cnt_d;
      abort_q    <= abort_d;
      load_q     <= load_d;
      acq_q      <= acq_d;
      force_q    <= force_d;
      data_en_q  <= data_en_d;
      done_q     <= done_d;
`ifdef SWEEP_ACQ_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign SweepAcq10BitDac                = dac_q;
  assign SweepAcqMicrorocSCParameterLoad = load_q;
  assign SweepAcqMicrorocAcqStartStop    = acq_q;
  assign SweepAcqForceMicrorocAcqReset   = force_q;
  assign SweepAcqData                    = data_q;
  assign SweepAcqData_en                 = data_en_q;
  assign SweepAcqDone                    = done_q;

endmodule

// File: tb/tb_sweep_acq_controller.sv
// Testbench for sweep_acq_controller: table-driven sweeps with a record scoreboard plus
// hand-written latency, abort, asynchronous-reset and (optional) timeout sequences.
`timescale 1ns/1ps
module tb_sweep_acq_controller;

  logic        Clk = 1'b0;
  logic        reset;
  logic        SweepStartStop;
  logic [9:0]  StartDac, EndDac;
  logic [15:0] MaxPackageNumber;
  logic        SCLoadDone = 1'b0;
  logic [15:0] ParallelData = 16'h0;
  logic        ParallelData_en = 1'b0;
  logic [9:0]  SweepAcq10BitDac;
  logic        SweepAcqMicrorocSCParameterLoad;
  logic        SweepAcqMicrorocAcqStartStop;
  logic        SweepAcqForceMicrorocAcqReset;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        SweepAcqDone;

  localparam logic [15:0] TAIL = 16'hFFFF;

  sweep_acq_controller #(
    .TAIL_WORD(TAIL),
    .SETTLE_CYCLES(16'd4)
`ifdef SWEEP_ACQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32'd50)
`endif
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .SweepStartStop(SweepStartStop),
    .StartDac(StartDac),
    .EndDac(EndDac),
    .MaxPackageNumber(MaxPackageNumber),
    .SCLoadDone(SCLoadDone),
    .ParallelData(ParallelData),
    .ParallelData_en(ParallelData_en),
    .SweepAcq10BitDac(SweepAcq10BitDac),
    .SweepAcqMicrorocSCParameterLoad(SweepAcqMicrorocSCParameterLoad),
    .SweepAcqMicrorocAcqStartStop(SweepAcqMicrorocAcqStartStop),
    .SweepAcqForceMicrorocAcqReset(SweepAcqForceMicrorocAcqReset),
    .SweepAcqData(SweepAcqData),
    .SweepAcqData_en(SweepAcqData_en),
    .SweepAcqDone(SweepAcqDone)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0]  sdac;
    logic [9:0]  edac;
    logic [15:0] maxp;
    int          tails;
    bit          flood;
    int          exp_loads;
    bit          exp_acq;
    logic [9:0]  exp_dac;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          loads, acq_cycles, force_cycles;
  int          tails_per_step = 0;
  bit          flood = 1'b0;

  function automatic logic [15:0] tr(input logic [15:0] cnt);
`ifdef SWEEP_ACQ_TIMEOUT_EN
    return {1'b1, cnt[14:0]};
`else
    return cnt;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock step: observe outputs at the falling edge and score any record word.
  task automatic tick();
    logic [15:0] w;
    @(negedge Clk);
    if (SweepAcqMicrorocSCParameterLoad) loads++;
    if (SweepAcqMicrorocAcqStartStop)    acq_cycles++;
    if (SweepAcqForceMicrorocAcqReset)   force_cycles++;
    if (SweepAcqData_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL data_unexpected: got %h expected no word", SweepAcqData);
      end else begin
        w = exp_q.pop_front();
        check("data_word", {16'h0, SweepAcqData}, {16'h0, w});
      end
    end
  endtask

  task automatic clear_counts();
    loads = 0;
    acq_cycles = 0;
    force_cycles = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 4000; i++) begin
      if (SweepAcqDone) break;
      tick();
    end
    check(nm, {31'h0, SweepAcqDone}, 32'h1);
  endtask

  task automatic wait_acq(input string nm);
    for (int i = 0; i < 400; i++) begin
      if (SweepAcqMicrorocAcqStartStop) break;
      tick();
    end
    check(nm, {31'h0, SweepAcqMicrorocAcqStartStop}, 32'h1);
  endtask

  // Microroc / SC-block model: SCLoadDone 3 cycles after each load; during ACQ alternates a
  // non-tail word with a tail word until the per-step tail quota is used. Flood sends tails always.
  initial begin
    int  sc_cnt = 0;
    int  tails_left = 0;
    bit  phase = 1'b0;
    bit  acq_prev = 1'b0;
    forever begin
      @(negedge Clk);
      SCLoadDone = 1'b0;
      ParallelData_en = 1'b0;
      ParallelData = 16'h0000;
      if (SweepAcqMicrorocSCParameterLoad) sc_cnt = 3;
      else if (sc_cnt > 0) begin
        sc_cnt--;
        if (sc_cnt == 0) SCLoadDone = 1'b1;
      end
      if (SweepAcqMicrorocAcqStartStop && !acq_prev) begin
        tails_left = tails_per_step;
        phase = 1'b0;
      end
      acq_prev = SweepAcqMicrorocAcqStartStop;
      if (flood) begin
        ParallelData = TAIL;
        ParallelData_en = 1'b1;
      end else if (SweepAcqMicrorocAcqStartStop) begin
        if (!phase) begin
          ParallelData = 16'h00A5;
          ParallelData_en = 1'b1;
        end else if (tails_left > 0) begin
          ParallelData = TAIL;
          ParallelData_en = 1'b1;
          tails_left--;
        end
        phase = ~phase;
      end
    end
  end

  initial begin
    reset = 1'b1;
    SweepStartStop = 1'b0;
    StartDac = 10'd0;
    EndDac = 10'd0;
    MaxPackageNumber = 16'd0;
    clear_counts();

    vecs[0] = '{10'd5,    10'd7,    16'd2, 2, 1'b0, 3, 1'b1, 10'd7};
    vecs[1] = '{10'd9,    10'd4,    16'd2, 2, 1'b0, 0, 1'b0, 10'd7};
    vecs[2] = '{10'd100,  10'd100,  16'd0, 2, 1'b0, 1, 1'b0, 10'd100};
    vecs[3] = '{10'd1022, 10'd1023, 16'd1, 1, 1'b0, 2, 1'b1, 10'd1023};
    vecs[4] = '{10'd20,   10'd21,   16'd2, 0, 1'b1, 2, 1'b1, 10'd21};
    vecs[5] = '{10'd0,    10'd0,    16'd3, 3, 1'b0, 1, 1'b1, 10'd0};

    repeat (3) @(negedge Clk);
    check("rst_dac",   {22'h0, SweepAcq10BitDac}, 32'h0);
    check("rst_load",  {31'h0, SweepAcqMicrorocSCParameterLoad}, 32'h0);
    check("rst_acq",   {31'h0, SweepAcqMicrorocAcqStartStop}, 32'h0);
    check("rst_force", {31'h0, SweepAcqForceMicrorocAcqReset}, 32'h0);
    check("rst_data",  {15'h0, SweepAcqData_en, SweepAcqData}, 32'h0);
    check("rst_done",  {31'h0, SweepAcqDone}, 32'h0);
    reset = 1'b0;
    tick();

    // Empty sweep: Done two cycles after start, cleared when the start level drops.
    clear_counts();
    StartDac = 10'd9; EndDac = 10'd4; MaxPackageNumber = 16'd2;
    SweepStartStop = 1'b1;
    tick();
    check("empty_done_c1", {31'h0, SweepAcqDone}, 32'h0);
    tick();
    check("empty_done_c2", {31'h0, SweepAcqDone}, 32'h1);
    check("empty_loads", loads, 32'h0);
    SweepStartStop = 1'b0;
    tick();
    check("empty_done_clr", {31'h0, SweepAcqDone}, 32'h0);

    // Load pulse latency: IDLE cycle, then LOAD.
    clear_counts();
    StartDac = 10'd60; EndDac = 10'd60; MaxPackageNumber = 16'd0;
    exp_q.push_back(16'hC03C);
    exp_q.push_back(tr(16'd0));
    SweepStartStop = 1'b1;
    tick();
    check("load_lat_c1", {31'h0, SweepAcqMicrorocSCParameterLoad}, 32'h0);
    tick();
    check("load_lat_c2", {31'h0, SweepAcqMicrorocSCParameterLoad}, 32'h1);
    tick();
    check("load_one_cycle", {31'h0, SweepAcqMicrorocSCParameterLoad}, 32'h0);
    wait_done("lat_done");
    check("lat_words_left", exp_q.size(), 32'h0);
    SweepStartStop = 1'b0;
    tick();
    tick();

    foreach (vecs[k]) begin
      clear_counts();
      exp_q.delete();
      StartDac = vecs[k].sdac;
      EndDac = vecs[k].edac;
      MaxPackageNumber = vecs[k].maxp;
      tails_per_step = vecs[k].tails;
      flood = vecs[k].flood;
      for (int d = int'(vecs[k].sdac); d <= int'(vecs[k].edac); d++) begin
        exp_q.push_back(16'hC000 | 16'(d));
        exp_q.push_back(tr(vecs[k].maxp));
      end
      SweepStartStop = 1'b1;
      wait_done($sformatf("v%0d_done", k));
      check($sformatf("v%0d_words_left", k), exp_q.size(), 32'h0);
      check($sformatf("v%0d_loads", k), loads, vecs[k].exp_loads);
      check($sformatf("v%0d_acq_seen", k), {31'h0, acq_cycles > 0}, {31'h0, vecs[k].exp_acq});
      check($sformatf("v%0d_dac", k), {22'h0, SweepAcq10BitDac}, {22'h0, vecs[k].exp_dac});
      SweepStartStop = 1'b0;
      flood = 1'b0;
      tick();
      check($sformatf("v%0d_done_clr", k), {31'h0, SweepAcqDone}, 32'h0);
      tick();
    end

    // Abort in ACQ after one of three tails: no trailer, 2-cycle reset pulse, back to IDLE.
    clear_counts();
    exp_q.delete();
    StartDac = 10'd30; EndDac = 10'd31; MaxPackageNumber = 16'd3;
    tails_per_step = 1;
    exp_q.push_back(16'hC01E);
    SweepStartStop = 1'b1;
    wait_acq("abort_acq_up");
    repeat (4) tick();
    force_cycles = 0;
    SweepStartStop = 1'b0;
    tick();
    check("abort_acq_low", {31'h0, SweepAcqMicrorocAcqStartStop}, 32'h0);
    check("abort_force_c1", {31'h0, SweepAcqForceMicrorocAcqReset}, 32'h1);
    tick();
    check("abort_force_c2", {31'h0, SweepAcqForceMicrorocAcqReset}, 32'h1);
    tick();
    check("abort_force_c3", {31'h0, SweepAcqForceMicrorocAcqReset}, 32'h0);
    repeat (5) tick();
    check("abort_force_len", force_cycles, 32'h2);
    check("abort_done", {31'h0, SweepAcqDone}, 32'h0);
    check("abort_words_left", exp_q.size(), 32'h0);
    check("abort_loads", loads, 32'h1);

    // Asynchronous reset in the middle of an acquisition.
    clear_counts();
    exp_q.delete();
    StartDac = 10'd50; EndDac = 10'd50; MaxPackageNumber = 16'd3;
    exp_q.push_back(16'hC032);
    SweepStartStop = 1'b1;
    wait_acq("mrst_acq_up");
    tick();
    #2 reset = 1'b1;
    #1;
    check("mrst_acq", {31'h0, SweepAcqMicrorocAcqStartStop}, 32'h0);
    check("mrst_dac", {22'h0, SweepAcq10BitDac}, 32'h0);
    check("mrst_force", {31'h0, SweepAcqForceMicrorocAcqReset}, 32'h0);
    check("mrst_data", {15'h0, SweepAcqData_en, SweepAcqData}, 32'h0);
    @(negedge Clk);
    SweepStartStop = 1'b0;
    @(negedge Clk);
    reset = 1'b0;
    tick();
    check("mrst_words_left", exp_q.size(), 32'h0);
    check("mrst_done", {31'h0, SweepAcqDone}, 32'h0);

`ifdef SWEEP_ACQ_TIMEOUT_EN
    // No tails at all: acquisition gives up after 50 ACQ cycles.
    clear_counts();
    exp_q.delete();
    StartDac = 10'd40; EndDac = 10'd40; MaxPackageNumber = 16'd5;
    tails_per_step = 0;
    exp_q.push_back(16'hC028);
    exp_q.push_back(16'h8000);
    SweepStartStop = 1'b1;
    wait_done("tmo_done");
    check("tmo_acq_cycles", acq_cycles, 32'd50);
    check("tmo_words_left", exp_q.size(), 32'h0);
    SweepStartStop = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
